// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the game step counter.
//                mode_e  - step-mode encodings carried on ctrl
//                state_e - control FSM states (IDLE / RUN / OVER)
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int c_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_UP1 = 2'b00,
    MODE_UP2 = 2'b01,
    MODE_DN1 = 2'b10,
    MODE_DN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

endpackage : game_pkg
`default_nettype wire

// File: rtl/game_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_counter_if
//  Description : Control/result bundle between the game logic (master) and
//                the game_counter block (slave).
//  Signals     : ctrl     - step mode (master -> slave)
//                init     - load request (master -> slave)
//                init_val - load value (master -> slave)
//                gameover - freeze level from the flag counters (master -> slave)
//                count    - current counter value (slave -> master)
//                winner   - pulse, count stepped into all-ones (slave -> master)
//                loser    - pulse, count stepped into zero (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_counter_if #(
  parameter int WIDTH = game_pkg::c_DEFAULT_WIDTH
);
  logic [1:0]       ctrl;
  logic             init;
  logic [WIDTH-1:0] init_val;
  logic             gameover;
  logic [WIDTH-1:0] count;
  logic             winner;
  logic             loser;

  modport master (
    output ctrl, init, init_val, gameover,
    input  count, winner, loser
  );

  modport slave (
    input  ctrl, init, init_val, gameover,
    output count, winner, loser
  );
endinterface : game_counter_if
`default_nettype wire

// File: rtl/game_counter_step.sv
`default_nettype none
// ============================================================================
//  Module      : game_counter_step
//  Description : Combinational next-count calculation for one step in the
//                selected mode, modulo 2^WIDTH, plus all-ones / zero detect
//                on the resulting value.
//  Ports       : i_count    - current count
//                i_mode     - step mode
//                o_next     - stepped count
//                o_all_ones - o_next is all-ones
//                o_zero     - o_next is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module game_counter_step
  import game_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire  [WIDTH-1:0] i_count,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_all_ones,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_TWO = WIDTH'(2);

  // Sums are kept at WIDTH bits so carry/borrow falls off naturally.
  always_comb begin
    o_next = i_count;
    case (i_mode)
      MODE_UP1: o_next = i_count + c_ONE;
      MODE_UP2: o_next = i_count + c_TWO;
      MODE_DN1: o_next = i_count - c_ONE;
      MODE_DN2: o_next = i_count - c_TWO;
      default:  o_next = i_count;
    endcase
  end

  assign o_all_ones = &o_next;
  assign o_zero     = ~|o_next;

endmodule : game_counter_step
`default_nettype wire

// File: rtl/game_counter.sv
`default_nettype none
// ============================================================================
//  Module      : game_counter
//  Description : Multimode step counter producing winner/loser pulses for
//                the downstream flag counters. Freezes in OVER once the
//                flag stage reports gameover; only rst leaves OVER.
//  Ports       : clk - clock, rising edge
//                rst - synchronous active-high reset
//                bus - game_counter_if.slave (ctrl, init, init_val,
//                      gameover in; count, winner, loser out)
//  Macro       : GAME_COUNTER_CTRL_SYNC_EN - when defined, ctrl is
//                registered once (reset 00) before it selects the step mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_counter
  import game_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire             clk,
  input  wire             rst,
  game_counter_if.slave   bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_winner;
  logic             r_loser;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;
  logic             w_zero;

`ifdef GAME_COUNTER_CTRL_SYNC_EN
  // Mode changes land one edge late; reset value selects up-by-1.
  logic [1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 2'b00;
    end else begin
      r_ctrl <= bus.ctrl;
    end
  end

  assign w_mode = mode_e'(r_ctrl);
`else
  assign w_mode = mode_e'(bus.ctrl);
`endif

  game_counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_count    (r_count),
    .i_mode     (w_mode),
    .o_next     (w_next),
    .o_all_ones (w_all_ones),
    .o_zero     (w_zero)
  );

  // Priority inside every state: rst > gameover > init > step.
  // Pulses are only ever raised on a step, so loads of all-ones/zero
  // and the reset-to-zero never generate winner/loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_winner <= 1'b0;
      r_loser  <= 1'b0;
    end else begin
      r_winner <= 1'b0;
      r_loser  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.gameover) begin
            r_state <= ST_OVER;
          end else if (bus.init) begin
            r_count <= bus.init_val;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.gameover) begin
            r_state <= ST_OVER;
          end else if (bus.init) begin
            r_count <= bus.init_val;
          end else begin
            r_count  <= w_next;
            r_winner <= w_all_ones;
            r_loser  <= w_zero;
          end
        end
        ST_OVER: begin
          r_state <= ST_OVER;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.count  = r_count;
  assign bus.winner = r_winner;
  assign bus.loser  = r_loser;

endmodule : game_counter
`default_nettype wire

// File: tb/tb_game_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_counter
//  Description : Self-checking bench for game_counter (WIDTH=4). Directed
//                scenarios checked against hand-derived constants, plus a
//                randomized run checked against an arithmetic reference
//                model of the counter's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_counter;

  localparam int WIDTH = 4;
  localparam int MODN  = 1 << WIDTH;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  game_counter_if #(.WIDTH(WIDTH)) bus ();

  game_counter #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_phase: 0 = waiting for first load, 1 = counting, 2 = frozen
  int m_phase;
  int m_count;
  bit m_win;
  bit m_los;
  int m_ctrl_prev;

  function automatic int step_delta(input int mode);
    case (mode)
      0: return 1;
      1: return 2;
      2: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic model_edge(input bit r, input int c, input bit in,
                            input int iv, input bit go);
    int mode;
`ifdef GAME_COUNTER_CTRL_SYNC_EN
    mode = m_ctrl_prev;
`else
    mode = c;
`endif
    m_ctrl_prev = r ? 0 : c;
    m_win = 0;
    m_los = 0;
    if (r) begin
      m_phase = 0;
      m_count = 0;
    end else if (m_phase == 2) begin
      // frozen
    end else if (go) begin
      m_phase = 2;
    end else if (in) begin
      m_count = iv;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_count = ((m_count + step_delta(mode)) % MODN + MODN) % MODN;
      m_win   = (m_count == MODN - 1);
      m_los   = (m_count == 0);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input bit r, input logic [1:0] c, input bit in,
                      input logic [3:0] iv, input bit go);
    rst          = r;
    bus.ctrl     = c;
    bus.init     = in;
    bus.init_val = iv;
    bus.gameover = go;
    model_edge(r, int'(c), in, int'(iv), go);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(1, 2'b11, 1, 4'hA, 0);
    tick(1, 2'b01, 1, 4'h5, 1);
    n_checks++;
    if (bus.count !== 4'h0 || bus.winner !== 1'b0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%h winner=%b loser=%b, required 0 0 0",
               bus.count, bus.winner, bus.loser);
    end
    // IDLE holds count without a load, even while ctrl selects a step
    tick(0, 2'b00, 0, 4'h0, 0);
    tick(0, 2'b10, 0, 4'h0, 0);
    n_checks++;
    if (bus.count !== 4'h0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: count=%h loser=%b, required 0 0",
               bus.count, bus.loser);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_c[4] = '{4'hD, 4'hE, 4'hF, 4'h0};
    logic       exp_w[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tick(1, 2'b00, 0, 4'h0, 0);
    tick(0, 2'b00, 1, 4'hD, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(0, 2'b00, 0, 4'h0, 0);
      n_checks++;
      if (bus.count !== exp_c[i] || bus.winner !== exp_w[i] || bus.loser !== exp_l[i]) begin
        n_fail++;
        $display("FAIL count_up[%0d]: count=%h w=%b l=%b, required %h %b %b",
                 i, bus.count, bus.winner, bus.loser, exp_c[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_down2_wrap();
    logic [3:0] exp_c[4] = '{4'h2, 4'h0, 4'hE, 4'hC};
    logic       exp_l[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tick(0, 2'b11, 1, 4'h4, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 2'b11, 0, 4'h0, 0);
      n_checks++;
      if (bus.count !== exp_c[i] || bus.winner !== 1'b0 || bus.loser !== exp_l[i]) begin
        n_fail++;
        $display("FAIL down2[%0d]: count=%h w=%b l=%b, required %h 0 %b",
                 i, bus.count, bus.winner, bus.loser, exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_up2_wrap();
    logic [3:0] exp_c[3] = '{4'hE, 4'h0, 4'h2};
    logic       exp_l[3] = '{1'b0, 1'b1, 1'b0};
    tick(0, 2'b01, 1, 4'hC, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 2'b01, 0, 4'h0, 0);
      n_checks++;
      if (bus.count !== exp_c[i] || bus.winner !== 1'b0 || bus.loser !== exp_l[i]) begin
        n_fail++;
        $display("FAIL up2[%0d]: count=%h w=%b l=%b, required %h 0 %b",
                 i, bus.count, bus.winner, bus.loser, exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_load_extremes();
    tick(0, 2'b10, 1, 4'hF, 0);
    n_checks++;
    if (bus.count !== 4'hF || bus.winner !== 1'b0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL load_F: count=%h w=%b l=%b, required F 0 0",
               bus.count, bus.winner, bus.loser);
    end
    tick(0, 2'b10, 1, 4'h0, 0);
    n_checks++;
    if (bus.count !== 4'h0 || bus.winner !== 1'b0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL load_0: count=%h w=%b l=%b, required 0 0 0",
               bus.count, bus.winner, bus.loser);
    end
    tick(0, 2'b10, 0, 4'h0, 0);
    n_checks++;
    if (bus.count !== 4'hF || bus.winner !== 1'b1 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL step_to_F: count=%h w=%b l=%b, required F 1 0",
               bus.count, bus.winner, bus.loser);
    end
  endtask

  task automatic test_gameover_freeze();
    tick(0, 2'b00, 1, 4'h7, 0);
    tick(0, 2'b00, 1, 4'h3, 1);
    n_checks++;
    if (bus.count !== 4'h7 || bus.winner !== 1'b0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL gameover_hit: count=%h w=%b l=%b, required 7 0 0",
               bus.count, bus.winner, bus.loser);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 0);
      n_checks++;
      if (bus.count !== 4'h7 || bus.winner !== 1'b0 || bus.loser !== 1'b0) begin
        n_fail++;
        $display("FAIL frozen[%0d]: count=%h w=%b l=%b, required 7 0 0",
                 i, bus.count, bus.winner, bus.loser);
      end
    end
    tick(1, 2'b10, 0, 4'h0, 0);
    n_checks++;
    if (bus.count !== 4'h0 || bus.loser !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_from_over: count=%h loser=%b, required 0 0",
               bus.count, bus.loser);
    end
    // back in IDLE: a load must be accepted again
    tick(0, 2'b00, 1, 4'h9, 0);
    n_checks++;
    if (bus.count !== 4'h9) begin
      n_fail++;
      $display("FAIL reload_after_rst: count=%h, required 9", bus.count);
    end
  endtask

  task automatic test_ctrl_change();
    logic [3:0] exp_c[2];
`ifdef GAME_COUNTER_CTRL_SYNC_EN
    exp_c = '{4'h6, 4'h5};
`else
    exp_c = '{4'h4, 4'h3};
`endif
    tick(0, 2'b00, 1, 4'h4, 0);
    tick(0, 2'b00, 0, 4'h0, 0);
    n_checks++;
    if (bus.count !== 4'h5) begin
      n_fail++;
      $display("FAIL ctrl_setup: count=%h, required 5", bus.count);
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 2'b10, 0, 4'h0, 0);
      n_checks++;
      if (bus.count !== exp_c[i]) begin
        n_fail++;
        $display("FAIL ctrl_change[%0d]: count=%h, required %h",
                 i, bus.count, exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    bit r, in, go;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      go = ($urandom_range(0, 99) < 2);
      in = ($urandom_range(0, 99) < 10);
      tick(r, 2'($urandom_range(0, 3)), in, 4'($urandom_range(0, 15)), go);
      n_checks++;
      if (int'(bus.count) !== m_count || bus.winner !== m_win || bus.loser !== m_los) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%h w=%b l=%b, required %h %b %b",
                 i, bus.count, bus.winner, bus.loser, m_count[3:0], m_win, m_los);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    m_phase      = 0;
    m_count      = 0;
    m_win        = 0;
    m_los        = 0;
    m_ctrl_prev  = 0;
    rst          = 1'b1;
    bus.ctrl     = 2'b00;
    bus.init     = 1'b0;
    bus.init_val = '0;
    bus.gameover = 1'b0;

    test_reset();
    test_count_up();
    test_down2_wrap();
    test_up2_wrap();
    test_load_extremes();
    test_gameover_freeze();
    test_ctrl_change();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_game_counter
`default_nettype wire
